// File: rtl/prog_imem.sv
// Run-time loadable instruction memory: valid/ready load stream fills the RAM, fetches are registered.
// Optional IMEM_CHECKSUM_EN adds a running XOR checksum of the words accepted by the current load.
module prog_imem #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        DEPTH     = 16,
    parameter logic [DATA_W-1:0]  FILL_WORD = 8'hC3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   prog_len,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_fault,
    output logic [DATA_W-1:0] load_checksum
);

    localparam int unsigned    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY
    } state_e;

    state_e            state_q;
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   prog_len_q;
    logic              load_ready_q;
    logic              load_done_q;
    logic [DATA_W-1:0] instr_q;
    logic              instr_valid_q;
    logic              addr_fault_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              transfer;
    logic              load_end;
    logic              fetch_hit;
    logic [ADDR_W:0]   wr_ptr_d;

    // load_ready_q is only ever high in LOAD, so a transfer is always a LOAD-state write.
    assign transfer  = load_valid & load_ready_q;
    assign load_end  = transfer & (load_last | (wr_ptr_q == LAST_IDX));
    assign wr_ptr_d  = wr_ptr_q + ONE;
    assign fetch_hit = (state_q == ST_READY) && ({1'b0, fetch_addr} < prog_len_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            prog_len_q    <= '0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            instr_q       <= FILL_WORD;
            instr_valid_q <= 1'b0;
            addr_fault_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_READY: begin
                    if (load_start) begin
                        state_q      <= ST_LOAD;
                        wr_ptr_q     <= '0;
                        prog_len_q   <= '0;
                        load_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (transfer) begin
                        wr_ptr_q <= wr_ptr_d;
                    end
                    if (load_end) begin
                        state_q      <= ST_READY;
                        prog_len_q   <= wr_ptr_d;
                        load_ready_q <= 1'b0;
                        load_done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Fetch sees the state and length of this cycle, so a fetch beside load_start uses the old program.
            if (fetch_req) begin
                instr_valid_q <= 1'b1;
                addr_fault_q  <= ~fetch_hit;
                instr_q       <= fetch_hit ? mem_q[fetch_addr[IDX_W-1:0]] : FILL_WORD;
            end else begin
                instr_valid_q <= 1'b0;
                addr_fault_q  <= 1'b0;
            end
        end
    end

    // NOTE: the RAM has no reset; stale contents are masked by prog_len and the READY state instead.
    always_ff @(posedge clk) begin
        if (transfer && !reset) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= load_data;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_q <= '0;
        end else if ((state_q != ST_LOAD) && load_start) begin
            checksum_q <= '0;
        end else if (transfer) begin
            checksum_q <= checksum_q ^ load_data;
        end
    end

    assign load_checksum = checksum_q;
`else
    assign load_checksum = '0;
`endif

    assign load_ready  = load_ready_q;
    assign load_done   = load_done_q;
    assign prog_len    = prog_len_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_fault  = addr_fault_q;

endmodule

// File: tb/tb_prog_imem.sv
// Scoreboarded bench for prog_imem: a cycle-stepping driver feeds a behavioural load/fetch model,
// and a negedge monitor pops expected fetch responses.
module tb_prog_imem;

    localparam int          DEPTH = 16;
    localparam logic [7:0]  FILL  = 8'hC3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_valid = 1'b0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_done;
    logic [8:0]  prog_len;
    logic        fetch_req = 1'b0;
    logic [7:0]  fetch_addr = '0;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        addr_fault;
    logic [7:0]  load_checksum;

    prog_imem dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
        .prog_len(prog_len), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault),
        .load_checksum(load_checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] word;
        logic       fault;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Behavioural model: program image, how many words are usable, and whether a load is in progress.
    logic [7:0] m_mem [DEPTH];
    bit         m_loading = 1'b0;
    bit         m_ready = 1'b0;
    int         m_cnt = 0;
    int         m_len = 0;
    logic [7:0] m_chk = '0;
    bit         m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: record expected fetch response, clock, advance the model, compare the load-side outputs.
    task automatic tick();
        exp_t e;
        if (fetch_req && !reset) begin
            e.due = cyc + 1;
            if (m_ready && int'(fetch_addr) < m_len) begin
                e.word  = m_mem[fetch_addr];
                e.fault = 1'b0;
            end else begin
                e.word  = FILL;
                e.fault = 1'b1;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        m_done = 1'b0;
        if (reset) begin
            m_loading = 1'b0;
            m_ready   = 1'b0;
            m_len     = 0;
            m_chk     = '0;
        end else if (m_loading) begin
            if (load_valid) begin
                m_mem[m_cnt] = load_data;
                m_cnt++;
                m_chk ^= load_data;
                if (load_last || m_cnt == DEPTH) begin
                    m_loading = 1'b0;
                    m_ready   = 1'b1;
                    m_len     = m_cnt;
                    m_done    = 1'b1;
                end
            end
        end else if (load_start) begin
            m_loading = 1'b1;
            m_ready   = 1'b0;
            m_cnt     = 0;
            m_len     = 0;
            m_chk     = '0;
        end
        #1;
        if (mon_en) begin
            check("load_ready", load_ready, m_loading);
            check("load_done", load_done, m_done);
            check("prog_len", prog_len, m_len);
`ifdef IMEM_CHECKSUM_EN
            check("load_checksum", load_checksum, m_chk);
`else
            check("load_checksum", load_checksum, 0);
`endif
        end
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch_req  = 1'b0;
    endtask

    // Pulse load_start, then stream words with the given valid probability until the model stops accepting.
    task automatic do_load(input logic [7:0] w[$], input bit use_last, input int valid_pct);
        int idx = 0;
        int budget = 400;
        idle_inputs();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        while (idx < w.size() && m_loading && budget > 0) begin
            bit was_loading = m_loading;
            load_valid = ($urandom_range(99) < valid_pct);
            load_data  = w[idx];
            load_last  = use_last && (idx == w.size() - 1);
            tick();
            if (was_loading && load_valid) idx++;
            budget--;
        end
        if (budget == 0) check("load_budget", 0, 1);
        idle_inputs();
    endtask

    task automatic fetch_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = 8'(a);
            tick();
        end
        fetch_req = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    check("instr_valid", instr_valid, 1);
                    check("instr", instr, e.word);
                    check("addr_fault", addr_fault, e.fault);
                end else begin
                    check("idle_instr_valid", instr_valid, 0);
                    check("idle_addr_fault", addr_fault, 0);
                end
            end
        end
    end

    initial begin : driver
        logic [7:0] words[$];

        // Reset and reset values.
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        mon_en = 1'b1;
        check("reset_instr", instr, FILL);
        check("reset_valid", instr_valid, 0);
        check("reset_fault", addr_fault, 0);
        check("reset_prog_len", prog_len, 0);
        check("reset_load_ready", load_ready, 0);
        tick();

        // Fetch before any load faults.
        fetch_range(0, 0);
        tick();

        // Directed load of the reference program.
        words = '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3};
        do_load(words, 1'b1, 100);
        tick();
        check("prog_len_5", prog_len, 5);
`ifdef IMEM_CHECKSUM_EN
        check("checksum_5f", load_checksum, 8'h5F);
`endif
        fetch_range(0, 5);
        tick();

        // Seventeen words without load_last: fills at DEPTH, the 17th stays held.
        words.delete();
        for (int i = 0; i < 17; i++) words.push_back(8'($urandom));
        do_load(words, 1'b0, 100);
        load_valid = 1'b1;
        load_data  = words[16];
        for (int i = 0; i < 3; i++) tick();
        check("full_prog_len", prog_len, DEPTH);
        check("full_ready_low", load_ready, 0);
        idle_inputs();
        fetch_range(0, 17);
        tick();

        // Five-word load with random valid gaps.
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(8'($urandom));
        do_load(words, 1'b1, 50);
        tick();
        check("gap_prog_len", prog_len, 5);
        fetch_range(0, 7);

        // Reset after two of five words.
        idle_inputs();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_data = 8'($urandom);
            tick();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midload_prog_len", prog_len, 0);
        fetch_range(0, 0);
        tick();

        // Fetch together with load_start in READY returns the old word; fetch during LOAD faults.
        words = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
        do_load(words, 1'b1, 100);
        tick();
        fetch_req  = 1'b1;
        fetch_addr = 8'd2;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        fetch_addr = 8'd0;
        load_valid = 1'b1;
        load_data  = 8'h77;
        tick();
        idle_inputs();
        check("reload_ready", load_ready, 1);
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_data  = 8'h88;
        tick();
        idle_inputs();
        fetch_range(0, 2);

        // Random mix of load and fetch activity.
        for (int i = 0; i < 300; i++) begin
            load_start = ($urandom_range(99) < 6);
            load_valid = ($urandom_range(99) < 50);
            load_last  = ($urandom_range(99) < 15);
            load_data  = 8'($urandom);
            fetch_req  = ($urandom_range(99) < 60);
            fetch_addr = 8'($urandom_range(19));
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_imem.md
Name: prog_imem

Overview:
Parametrised, run-time loadable instruction memory for the microprocessor datapath. It replaces a fixed combinational program store with a RAM that is filled through a valid/ready load stream. Fetches are registered with one-cycle latency. Out-of-range or not-ready fetches are flagged and return a safe fill word.

Parameters:
DATA_W, 8, instruction width in bits
ADDR_W, 8, fetch/load address width
DEPTH, 16, number of instruction words (DEPTH <= 2**ADDR_W)
FILL_WORD, 8'hC3, word returned on a faulting fetch (halt encoding), DATA_W bits

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
load_start  in  1  one-cycle pulse: begin new program load
load_data  in  DATA_W  instruction word to store
load_valid  in  1  load_data valid
load_last  in  1  qualifies final word of load (sampled with load_valid)
load_ready  out  1  memory accepts load word this cycle
load_done  out  1  one-cycle pulse when load completes
prog_len  out  ADDR_W+1  number of valid words currently loaded
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  fetch address
instr  out  DATA_W  fetched instruction (registered)
instr_valid  out  1  instr valid, one cycle after fetch_req
addr_fault  out  1  fetch was out of range or memory not READY
load_checksum  out  DATA_W  XOR of loaded words (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, wr_ptr=0, prog_len=0, load_ready=0, load_done=0, instr=FILL_WORD, instr_valid=0, addr_fault=0, load_checksum=0. RAM contents not cleared.
- FSM states: IDLE, LOAD, READY.
- IDLE/READY --load_start--> LOAD: wr_ptr<=0, prog_len<=0, checksum<=0. load_start in LOAD ignored.
- LOAD: load_ready=1 while wr_ptr<DEPTH. Transfer = load_valid & load_ready: mem[wr_ptr]<=load_data, wr_ptr++.
- LOAD exit: transfer with load_last=1, or transfer writing word index DEPTH-1 (load_last ignored beyond it). Next cycle state=READY, prog_len=words written, load_done=1 for exactly one cycle.
- load_valid with load_ready=0 is not consumed; source holds data.
- Fetch (any state): fetch_req at cycle N -> cycle N+1 instr_valid=1. If state==READY and fetch_addr<prog_len: instr=mem[fetch_addr], addr_fault=0. Otherwise instr=FILL_WORD, addr_fault=1.
- No fetch_req: instr_valid=0, addr_fault=0, instr holds last value.
- Simultaneous fetch_req and load_start in READY: fetch serviced from old contents and prog_len; state goes LOAD.
- Fetch in same cycle as a load write: treated as not READY (fault).
- Reset mid-load: returns to IDLE, prog_len=0; partial data unusable until full reload.
- prog_len saturates at DEPTH; no wrap of wr_ptr.

Optional Feature:
IMEM_CHECKSUM_EN defined: load_checksum = running XOR of all words accepted since last load_start, cleared by reset and load_start, final value stable in READY. Undefined: load_checksum tied to 0, no checksum register.

Test Plan:
- Reset then fetch addr 0 -> next cycle instr=8'hC3, instr_valid=1, addr_fault=1.
- load_start, stream 44,49,18,89,C3 (hex, last on C3) -> load_done pulse once, prog_len=5, checksum=8'h5F (with IMEM_CHECKSUM_EN).
- After load, fetch addrs 0..4 back-to-back -> instr 44,49,18,89,C3 one cycle later each, addr_fault=0. Fetch addr 5 -> instr=C3, addr_fault=1.
- Stream 17 words with DEPTH=16, no load_last -> load_ready drops after 16th, load_done pulse, prog_len=16, 17th word held unconsumed.
- Random load_valid gaps (valid 50%) during 5-word load -> identical contents and prog_len=5.
- Assert reset after 2 of 5 words -> state IDLE, prog_len=0, fetch addr 0 faults. Fetch+load_start same cycle in READY -> old word returned, then LOAD.
